eth_udp_tx_build: RTL and testbench
===================================

// Module: eth_udp_tx_build
// PURPOSE
//  Builds one Ethernet II / IPv4 / UDP frame per request and streams it bytewise (dst MAC first) to the RMII TX MAC.
//  The MAC adds preamble, SFD and FCS. This block adds no preamble, SFD or FCS.
//  It fills the headers, computes the IPv4 header checksum, pulls the payload from the user, and pads to the 60-byte minimum.
//  It is the transmit counterpart of the RX parser; it carries telemetry and replies from the PID core.
// PARAMETERS
//  LOCAL_MAC    48'h02_00_00_00_00_01  source MAC
//  LOCAL_IP     32'hC0A8_0132          source IP, 192.168.1.50
//  TTL          8'd64                  IPv4 TTL
//  MAX_PAYLOAD  16'd1472               largest accepted payload_len
// PORTS
//  clk50          in   1   50 MHz clock
//  rst_n          in   1   synchronous reset, active-low
//  start          in   1   one-cycle request; sampled only in IDLE
//  dst_mac        in   48  latched on start
//  dst_ip         in   32  latched on start
//  src_port       in   16  latched on start
//  dst_port       in   16  latched on start
//  payload_len    in   16  number of payload bytes, 0..MAX_PAYLOAD; latched on start
//  pl_data        in   8   payload byte
//  pl_valid       in   1   pl_data is valid
//  pl_ready       out  1   payload byte consumed this cycle when pl_valid & pl_ready
//  tx_byte        out  8   frame byte
//  tx_valid       out  1   tx_byte is valid
//  tx_ready       in   1   MAC accepts; transfer occurs when tx_valid & tx_ready
//  tx_last        out  1   tx_byte is the final frame byte
//  busy           out  1   high whenever state != IDLE
//  frame_sent     out  1   one-cycle pulse, cycle after the last byte transfers
//  len_err        out  1   one-cycle pulse: start with payload_len > MAX_PAYLOAD; request dropped
// BEHAVIOUR
//  Reset values:
//   - All outputs 0, state IDLE, ip_id 0.
//   - Reset mid-frame aborts immediately; tx_valid drops the next cycle and no tail bytes are sent.
//  States: IDLE -> CSUM -> HDR -> PAYLOAD -> PAD -> DONE -> IDLE.
//   - PAYLOAD is skipped if len == 0.
//   - PAD is skipped if len >= 18.
//  IDLE:
//   - On start with a valid len: latch all inputs and go to CSUM.
//   - On start with len > MAX_PAYLOAD: pulse len_err and stay in IDLE.
//   - start while busy is ignored.
//  CSUM (11 cycles):
//   - Cycles 1-10 accumulate one 16-bit word each into a 20-bit sum, in this order:
//     4500, 20+8+len, ip_id, 4000 (DF), {TTL,8'h11}, 0, LOCAL_IP hi, LOCAL_IP lo, dst_ip hi, dst_ip lo.
//   - Cycle 11 folds the carries twice and inverts the result; this is csum.
//  HDR: 42 bytes, big-endian, in this order:
//   - dst_mac, LOCAL_MAC, 0800
//   - IP header: 45 00, total_len, ip_id, 40 00, TTL, 11, csum, LOCAL_IP, dst_ip
//   - UDP header: src_port, dst_port, udp_len = 8+len, checksum 0000
//  Output register and handshake:
//   - The output is a one-byte register that loads when !tx_valid | tx_ready.
//   - tx_byte and tx_last stay stable while tx_valid & !tx_ready.
//  PAYLOAD:
//   - pl_ready = (state == PAYLOAD) & (!tx_valid | tx_ready) & (pl_cnt < len).
//   - If pl_valid is low, tx_valid deasserts and no bubble byte is inserted.
//  PAD:
//   - Emits zero bytes until the frame totals 60 bytes (pad = 18 - len when len < 18).
//  tx_last:
//   - Set on byte index max(42+len, 60) - 1.
//  DONE:
//   - Entered when the last byte transfers.
//   - Pulses frame_sent, increments ip_id (16-bit wrap FFFF -> 0000), returns to IDLE.
//   - busy is low the cycle after frame_sent, so back-to-back start is accepted then.
//  Widths:
//   - Byte counter is 11 bits (max 1514).
//   - total_len and udp_len are 16 bits and cannot overflow given MAX_PAYLOAD.
// STRUCTURE
//  Package eth_pkg holds:
//   - ETHERTYPE_IPV4 = 16'h0800, ETHERTYPE_ARP = 16'h0806, IP_PROTO_UDP = 8'h11
//   - ETH_HDR_LEN = 14, IP_HDR_LEN = 20, UDP_HDR_LEN = 8, ETH_MIN_NOFCS = 60
//   - the state enum
//  Sub-module ipv4_csum_accum:
//   - clear / add_word / fold control, 16-bit csum output.
//   - Reused later by the ICMP echo responder.
// TESTING
//  1. Reset; len=4, dst_ip C0A8010A, ports 1234->5678, data DE AD BE EF, tx_ready=1.
//     -> 60 bytes; total_len 0020; udp_len 000C; csum B740; 14 zero pad bytes; tx_last on byte 59.
//  2. Same request again.
//     -> ip_id 0001, csum B73F, frame_sent once per frame.
//  3. len=100 with tx_ready toggled on a 1-in-3 pattern.
//     -> 142 bytes, none skipped or duplicated; tx_byte stable while stalled; no pad.
//  4. len=0 -> 42 header bytes followed by 18 zero bytes; pl_ready never high.
//     len=18 -> exactly 60 bytes, no pad.
//  5. pl_valid low for 5 cycles mid-payload.
//     -> tx_valid low during the gap; byte order intact.
//     start pulsed while busy -> ignored.
//     len=1473 -> len_err pulse, busy stays 0.
//  6. rst_n asserted at byte 30.
//     -> tx_valid 0 next cycle; next frame starts clean with ip_id 0000.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet/IPv4/UDP constants and transmit-builder state type
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam int ETH_HDR_LEN   = 14;
    localparam int IP_HDR_LEN    = 20;
    localparam int UDP_HDR_LEN   = 8;
    localparam int ETH_MIN_NOFCS = 60;
    localparam int HDR_LEN       = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSUM,
        ST_HDR,
        ST_PAYLOAD,
        ST_PAD,
        ST_DONE
    } tx_state_t;

    // Index of the final frame byte; short frames are padded to the 60-byte minimum.
    function automatic logic [10:0] frame_last_idx(input logic [15:0] len);
        logic [15:0] total;
        total = 16'(HDR_LEN) + len;
        if (total < 16'(ETH_MIN_NOFCS))
            return 11'(ETH_MIN_NOFCS - 1);
        else
            return 11'(total - 16'd1);
    endfunction

endpackage

// File: rtl/eth_udp_tx_build_if.sv
// rtl/eth_udp_tx_build_if.sv - request, payload and frame-byte signals of the UDP transmit builder
interface eth_udp_tx_build_if;

    logic        start;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] payload_len;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        frame_sent;
    logic        len_err;

    modport master (
        output start, dst_mac, dst_ip, src_port, dst_port, payload_len,
        output pl_data, pl_valid, tx_ready,
        input  pl_ready, tx_byte, tx_valid, tx_last, busy, frame_sent, len_err
    );

    modport slave (
        input  start, dst_mac, dst_ip, src_port, dst_port, payload_len,
        input  pl_data, pl_valid, tx_ready,
        output pl_ready, tx_byte, tx_valid, tx_last, busy, frame_sent, len_err
    );

endinterface

// File: rtl/ipv4_csum_accum.sv
// rtl/ipv4_csum_accum.sv - ones-complement 16-bit word accumulator for IPv4-style header checksums
module ipv4_csum_accum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_add_word,
    input  logic [15:0] i_word,
    input  logic        i_fold,
    output logic [15:0] o_csum
);

    logic [19:0] r_sum;
    logic [15:0] r_csum;
    logic [16:0] w_fold1;
    logic [16:0] w_fold2;

    // Two end-around carry folds are enough for up to 16 words in a 20-bit sum.
    assign w_fold1 = {1'b0, r_sum[15:0]} + {13'd0, r_sum[19:16]};
    assign w_fold2 = {1'b0, w_fold1[15:0]} + {16'd0, w_fold1[16]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_csum <= '0;
        end else begin
            if (i_clear)
                r_sum <= '0;
            else if (i_add_word)
                r_sum <= r_sum + {4'd0, i_word};
            if (i_fold)
                r_csum <= ~w_fold2[15:0];
        end
    end

    assign o_csum = r_csum;

endmodule

// File: rtl/eth_udp_tx_build.sv
// rtl/eth_udp_tx_build.sv - builds one Ethernet II / IPv4 / UDP frame per request, streamed bytewise to the MAC
module eth_udp_tx_build
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP    = 32'hC0A8_0132,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic              clk50,
    input  logic              rst_n,
    eth_udp_tx_build_if.slave bus
);

    tx_state_t   r_state, w_state_nxt;
    logic [3:0]  r_cyc;
    logic [10:0] r_byte_idx;
    logic [10:0] r_pl_cnt;
    logic [10:0] r_last_idx;
    logic [15:0] r_len;
    logic [15:0] r_ip_id;
    logic [15:0] r_src_port;
    logic [15:0] r_dst_port;
    logic [47:0] r_dst_mac;
    logic [31:0] r_dst_ip;
    logic [7:0]  r_tx_byte;
    logic        r_tx_valid;
    logic        r_tx_last;
    logic        r_len_err;

    logic        w_load_en;
    logic        w_last_pend;
    logic        w_start_ok;
    logic        w_start_bad;
    logic        w_pl_ready;
    logic        w_load;
    logic        w_drop;
    logic        w_pl_take;
    logic        w_csum_add;
    logic        w_csum_fold;
    logic [7:0]  w_byte;
    logic [7:0]  w_hdr_byte;
    logic [5:0]  w_hdr_sel;
    logic [15:0] w_total_len;
    logic [15:0] w_udp_len;
    logic [15:0] w_csum_word;
    logic [15:0] w_csum;
    logic [335:0] w_hdr;

    assign w_total_len = r_len + 16'(IP_HDR_LEN + UDP_HDR_LEN);
    assign w_udp_len   = r_len + 16'(UDP_HDR_LEN);

    // Whole 42-byte header as one big-endian vector; byte 0 sits in the top bits.
    assign w_hdr = {r_dst_mac, LOCAL_MAC, ETHERTYPE_IPV4,
                    8'h45, 8'h00, w_total_len, r_ip_id, 16'h4000,
                    TTL, IP_PROTO_UDP, w_csum, LOCAL_IP, r_dst_ip,
                    r_src_port, r_dst_port, w_udp_len, 16'h0000};
    assign w_hdr_sel  = 6'(HDR_LEN - 1) - r_byte_idx[5:0];
    assign w_hdr_byte = w_hdr[{w_hdr_sel, 3'b000} +: 8];

    assign w_load_en   = !r_tx_valid || bus.tx_ready;
    assign w_last_pend = r_tx_valid && r_tx_last;
    assign w_start_ok  = bus.start && (r_state == ST_IDLE) && (bus.payload_len <= MAX_PAYLOAD);
    assign w_start_bad = bus.start && (r_state == ST_IDLE) && (bus.payload_len > MAX_PAYLOAD);
    assign w_pl_ready  = (r_state == ST_PAYLOAD) && w_load_en && ({5'd0, r_pl_cnt} < r_len);

    always_comb begin
        w_csum_word = 16'h0000;
        case (r_cyc)
            4'd0:    w_csum_word = 16'h4500;
            4'd1:    w_csum_word = w_total_len;
            4'd2:    w_csum_word = r_ip_id;
            4'd3:    w_csum_word = 16'h4000;
            4'd4:    w_csum_word = {TTL, IP_PROTO_UDP};
            4'd6:    w_csum_word = LOCAL_IP[31:16];
            4'd7:    w_csum_word = LOCAL_IP[15:0];
            4'd8:    w_csum_word = r_dst_ip[31:16];
            4'd9:    w_csum_word = r_dst_ip[15:0];
            default: w_csum_word = 16'h0000;
        endcase
    end

    ipv4_csum_accum u_csum (
        .clk        (clk50),
        .rst_n      (rst_n),
        .i_clear    (w_start_ok),
        .i_add_word (w_csum_add),
        .i_word     (w_csum_word),
        .i_fold     (w_csum_fold),
        .o_csum     (w_csum)
    );

    always_ff @(posedge clk50) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_pl_take   = 1'b0;
        w_byte      = 8'h00;
        w_csum_add  = 1'b0;
        w_csum_fold = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok)
                    w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (r_cyc == 4'd10) begin
                    w_csum_fold = 1'b1;
                    w_state_nxt = ST_HDR;
                end else begin
                    w_csum_add = 1'b1;
                end
            end
            ST_HDR, ST_PAYLOAD, ST_PAD: begin
                // Once the final byte is in the register, only its transfer matters.
                if (w_last_pend) begin
                    if (bus.tx_ready) begin
                        w_drop      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_load_en) begin
                    if (r_state == ST_HDR) begin
                        w_load = 1'b1;
                        w_byte = w_hdr_byte;
                        if (r_byte_idx == 11'(HDR_LEN - 1))
                            w_state_nxt = (r_len == 16'd0) ? ST_PAD : ST_PAYLOAD;
                    end else if (r_state == ST_PAYLOAD) begin
                        if (bus.pl_valid && w_pl_ready) begin
                            w_load    = 1'b1;
                            w_pl_take = 1'b1;
                            w_byte    = bus.pl_data;
                            if ((({5'd0, r_pl_cnt} + 16'd1) == r_len) &&
                                (r_len < 16'(ETH_MIN_NOFCS - HDR_LEN)))
                                w_state_nxt = ST_PAD;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else begin
                        w_load = 1'b1;
                        w_byte = 8'h00;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            r_cyc      <= '0;
            r_byte_idx <= '0;
            r_pl_cnt   <= '0;
            r_last_idx <= '0;
            r_len      <= '0;
            r_ip_id    <= '0;
            r_src_port <= '0;
            r_dst_port <= '0;
            r_dst_mac  <= '0;
            r_dst_ip   <= '0;
            r_tx_byte  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_len_err <= w_start_bad;
            if (w_start_ok) begin
                r_dst_mac  <= bus.dst_mac;
                r_dst_ip   <= bus.dst_ip;
                r_src_port <= bus.src_port;
                r_dst_port <= bus.dst_port;
                r_len      <= bus.payload_len;
                r_last_idx <= frame_last_idx(bus.payload_len);
                r_cyc      <= '0;
                r_byte_idx <= '0;
                r_pl_cnt   <= '0;
            end
            if (r_state == ST_CSUM)
                r_cyc <= r_cyc + 4'd1;
            if (w_load) begin
                r_tx_byte  <= w_byte;
                r_tx_valid <= 1'b1;
                r_tx_last  <= (r_byte_idx == r_last_idx);
                r_byte_idx <= r_byte_idx + 11'd1;
            end else if (w_drop) begin
                r_tx_valid <= 1'b0;
                r_tx_last  <= 1'b0;
            end
            if (w_pl_take)
                r_pl_cnt <= r_pl_cnt + 11'd1;
            if (r_state == ST_DONE)
                r_ip_id <= r_ip_id + 16'd1;
        end
    end

    assign bus.pl_ready   = w_pl_ready;
    assign bus.tx_byte    = r_tx_byte;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.tx_last    = r_tx_last;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.frame_sent = (r_state == ST_DONE);
    assign bus.len_err    = r_len_err;

endmodule

// File: tb/tb_eth_udp_tx_build.sv
// tb/tb_eth_udp_tx_build.sv - randomized self-checking bench for eth_udp_tx_build against a frame-level model
module tb_eth_udp_tx_build;

    localparam logic [47:0] L_MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] L_IP  = 32'hC0A8_0132;
    localparam logic [7:0]  L_TTL = 8'd64;

    logic clk50;
    logic rst_n;

    eth_udp_tx_build_if bus ();

    eth_udp_tx_build dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic        last_q[$];
    logic [7:0]  pl_src[$];
    logic [15:0] exp_id = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            exp_q.push_back(v[8*i +: 8]);
    endtask

    // Frame model: header fields, ones-complement checksum, payload, zero padding to 60 bytes.
    task automatic build_exp(input int len, input logic [47:0] mac, input logic [31:0] ip,
                             input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] id);
        int unsigned sum;
        logic [15:0] tl, ul, cs;
        exp_q.delete();
        tl  = 16'(28 + len);
        ul  = 16'(8 + len);
        sum = 32'h4500 + tl + id + 32'h4000 + {L_TTL, 8'h11} + L_IP[31:16] + L_IP[15:0]
              + ip[31:16] + ip[15:0];
        while (sum > 32'hFFFF)
            sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        push_be(mac, 6);
        push_be(L_MAC, 6);
        push_be(16'h0800, 2);
        push_be(16'h4500, 2);
        push_be(tl, 2);
        push_be(id, 2);
        push_be(16'h4000, 2);
        push_be({L_TTL, 8'h11}, 2);
        push_be(cs, 2);
        push_be(L_IP, 4);
        push_be(ip, 4);
        push_be(sp, 2);
        push_be(dp, 2);
        push_be(ul, 2);
        push_be(16'h0000, 2);
        for (int i = 0; i < len; i++)
            exp_q.push_back(pl_src[i]);
        while (exp_q.size() < 60)
            exp_q.push_back(8'h00);
    endtask

    task automatic gen_payload(input int len);
        pl_src.delete();
        for (int i = 0; i < len; i++)
            pl_src.push_back(8'($urandom));
    endtask

    // rmode: 0 always ready, 1 ready one cycle in three, 2 random ready
    task automatic run_frame(input int len, input logic [47:0] mac, input logic [31:0] ip,
                             input logic [15:0] sp, input logic [15:0] dp, input int rmode,
                             input int gap_at, input int spur_at, input int rst_at);
        int  cyc, pidx, gap_left, fs_cnt, fs_cyc, lt_cyc, stall_bad, gap_bad, plr_seen;
        int  nbad, nlast_bad, tail;
        bit  gap_used, done, prev_stall;
        logic [7:0] prev_byte;
        logic       prev_last;
        build_exp(len, mac, ip, sp, dp, exp_id);
        got_q.delete();
        last_q.delete();
        cyc = 0; pidx = 0; gap_left = 0; fs_cnt = 0; fs_cyc = -1; lt_cyc = -1;
        stall_bad = 0; gap_bad = 0; plr_seen = 0; gap_used = 0; done = 0; prev_stall = 0;
        prev_byte = 8'h00; prev_last = 1'b0;
        @(posedge clk50); #1;
        bus.dst_mac = mac; bus.dst_ip = ip; bus.src_port = sp; bus.dst_port = dp;
        bus.payload_len = 16'(len); bus.start = 1'b1; bus.tx_ready = 1'b1; bus.pl_valid = 1'b0;
        while (!done && cyc < 8000) begin
            @(posedge clk50); #1;
            bus.start = (cyc == spur_at);
            if (cyc == spur_at) begin
                bus.dst_ip = $urandom;
                bus.payload_len = 16'd3;
            end
            case (rmode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = (cyc % 3 == 0);
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (gap_at >= 0 && !gap_used && pidx == gap_at) begin
                gap_left = 5;
                gap_used = 1;
            end
            bus.pl_valid = (pidx < len) && (gap_left == 0);
            bus.pl_data  = (pidx < len) ? pl_src[pidx] : 8'h00;
            #1;
            if (prev_stall && ({bus.tx_valid, bus.tx_byte, bus.tx_last} !== {1'b1, prev_byte, prev_last}))
                stall_bad++;
            if (gap_left > 0 && gap_left < 5 && rmode == 0 && bus.tx_valid)
                gap_bad++;
            if (bus.pl_ready)
                plr_seen++;
            if (bus.frame_sent) begin
                fs_cnt++;
                fs_cyc = cyc;
                done = 1;
            end
            if (bus.pl_valid && bus.pl_ready)
                pidx++;
            if (bus.tx_valid && bus.tx_ready) begin
                got_q.push_back(bus.tx_byte);
                last_q.push_back(bus.tx_last);
                if (bus.tx_last)
                    lt_cyc = cyc;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_byte  = bus.tx_byte;
            prev_last  = bus.tx_last;
            if (gap_left > 0)
                gap_left--;
            cyc++;
            if (rst_at >= 0 && got_q.size() == rst_at) begin
                rst_n = 1'b0;
                bus.start = 1'b0;
                bus.pl_valid = 1'b0;
                @(posedge clk50); #1;
                chk("rst_tx_valid", bus.tx_valid, 1'b0);
                chk("rst_busy", bus.busy, 1'b0);
                rst_n = 1'b1;
                tail = 0;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk50); #1;
                    if (bus.tx_valid)
                        tail++;
                end
                chk("rst_no_tail", tail, 0);
                exp_id = 16'd0;
                return;
            end
        end
        bus.start = 1'b0;
        bus.pl_valid = 1'b0;
        chk("frame_done", done, 1'b1);
        chk("frame_len", got_q.size(), exp_q.size());
        nbad = 0;
        nlast_bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i])
                nbad++;
            if (last_q[i] !== (i == exp_q.size() - 1))
                nlast_bad++;
        end
        chk("frame_bytes", nbad, 0);
        chk("tx_last_pos", nlast_bad, 0);
        chk("stall_stable", stall_bad, 0);
        chk("frame_sent_cnt", fs_cnt, 1);
        chk("frame_sent_cycle", fs_cyc, lt_cyc + 1);
        if (gap_at >= 0)
            chk("gap_tx_valid", gap_bad, 0);
        if (len == 0)
            chk("pl_ready_len0", plr_seen, 0);
        @(posedge clk50); #1;
        chk("busy_after", bus.busy, 1'b0);
        chk("no_second_sent", bus.frame_sent, 1'b0);
        exp_id = exp_id + 16'd1;
    endtask

    initial begin
        int err_cnt, busy_seen, len, zeros;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.dst_mac = '0; bus.dst_ip = '0; bus.src_port = '0;
        bus.dst_port = '0; bus.payload_len = '0; bus.pl_data = '0; bus.pl_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk50);
        #1;
        chk("reset_tx_valid", bus.tx_valid, 1'b0);
        chk("reset_tx_last", bus.tx_last, 1'b0);
        chk("reset_tx_byte", bus.tx_byte, 8'h00);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_frame_sent", bus.frame_sent, 1'b0);
        chk("reset_len_err", bus.len_err, 1'b0);
        chk("reset_pl_ready", bus.pl_ready, 1'b0);
        rst_n = 1'b1;

        pl_src.delete();
        pl_src.push_back(8'hDE); pl_src.push_back(8'hAD);
        pl_src.push_back(8'hBE); pl_src.push_back(8'hEF);
        run_frame(4, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A8010A, 16'd1234, 16'd5678, 0, -1, -1, -1);
        chk("t1_total_len", {got_q[16], got_q[17]}, 16'h0020);
        chk("t1_udp_len", {got_q[38], got_q[39]}, 16'h000C);
        chk("t1_csum", {got_q[24], got_q[25]}, 16'hB740);
        chk("t1_payload", {got_q[42], got_q[43], got_q[44], got_q[45]}, 32'hDEADBEEF);
        zeros = 0;
        for (int i = 46; i < 60; i++)
            if (got_q[i] === 8'h00)
                zeros++;
        chk("t1_pad_zero", zeros, 14);
        chk("t1_last59", last_q[59], 1'b1);

        run_frame(4, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A8010A, 16'd1234, 16'd5678, 0, -1, -1, -1);
        chk("t2_ip_id", {got_q[18], got_q[19]}, 16'h0001);
        chk("t2_csum", {got_q[24], got_q[25]}, 16'hB73F);

        gen_payload(100);
        run_frame(100, 48'h11_22_33_44_55_66, 32'h0A000001, 16'h0400, 16'h0800, 1, -1, -1, -1);
        chk("t3_len", got_q.size(), 142);

        gen_payload(0);
        run_frame(0, 48'hFF_FF_FF_FF_FF_FF, 32'hC0A801FF, 16'd7, 16'd9, 0, -1, -1, -1);
        gen_payload(18);
        run_frame(18, 48'h02_AA_BB_CC_DD_EE, 32'hC0A80102, 16'd100, 16'd200, 2, -1, -1, -1);
        chk("t4_len18", got_q.size(), 60);

        gen_payload(40);
        run_frame(40, 48'h02_12_34_56_78_9A, 32'hC0A80103, 16'hABCD, 16'h1111, 0, 10, 20, -1);

        @(posedge clk50); #1;
        bus.start = 1'b1;
        bus.payload_len = 16'd1473;
        err_cnt = 0;
        busy_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk50); #1;
            bus.start = 1'b0;
            if (bus.len_err) err_cnt++;
            if (bus.busy) busy_seen++;
        end
        chk("len_err_pulse", err_cnt, 1);
        chk("len_err_busy", busy_seen, 0);

        gen_payload(1472);
        run_frame(1472, 48'h02_01_01_01_01_01, 32'hC0A80104, 16'd1, 16'd2, 0, -1, -1, -1);

        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(0, 60);
            gen_payload(len);
            run_frame(len, {16'h0200, 32'($urandom)}, $urandom, 16'($urandom), 16'($urandom),
                      2, (len > 3) ? $urandom_range(1, len - 1) : -1, -1, -1);
        end

        gen_payload(50);
        run_frame(50, 48'h02_33_33_33_33_33, 32'hC0A80105, 16'd3, 16'd4, 0, -1, -1, 30);
        gen_payload(8);
        run_frame(8, 48'h02_44_44_44_44_44, 32'hC0A80106, 16'd5, 16'd6, 0, -1, -1, -1);
        chk("t6_ip_id_clean", {got_q[18], got_q[19]}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
